sr_file_fwd: RTL and testbench
==============================

Name: sr_file_fwd

Overview:
- Special-register (SR) file for the pipeline's SR space: stores SR0..SR3 and commits WB-stage SR writes.
- Supplies `iw_src_sr_val` and `iw_tgt_sr_val` to the execute stage.
- Receiving end of the execute stage's SR result interface (`tgt_sr`, `tgt_sr_we`, `sr_result`). Forwards in-flight EX/MA SR results so a flag-setting op followed by a `JCCui` sees fresh flags with no stall.
- SR3 is a free-running cycle counter.

Parameters:
- `SR_W`, `` `HBIT_ADDR``+1 (48): width of every SR.
- `FL_W`, 4: number of implemented flag bits in SR2 (FL, Z/N/C/V at `` `FLAG_Z``/`` `FLAG_N``/`` `FLAG_C``/`` `FLAG_V``).
- `CYC_EN`, 1: when 1, SR3 auto-increments; when 0, SR3 is plain storage.

Ports:
- `iw_clk`  in  1  clock, rising edge.
- `iw_rst`  in  1  asynchronous reset, active-low.
- `iw_src_sr`  in  2  ID read index A.
- `iw_tgt_sr`  in  2  ID read index B.
- `ow_src_sr_val`  out  SR_W  forwarded value of `iw_src_sr`.
- `ow_tgt_sr_val`  out  SR_W  forwarded value of `iw_tgt_sr`.
- `iw_ex_tgt_sr`  in  2  EX-stage SR target (registered EX output).
- `iw_ex_tgt_sr_we`  in  1  EX-stage SR write valid.
- `iw_ex_sr_result`  in  SR_W  EX-stage SR result.
- `iw_ma_tgt_sr`  in  2  MA-stage SR target.
- `iw_ma_tgt_sr_we`  in  1  MA-stage SR write valid.
- `iw_ma_sr_result`  in  SR_W  MA-stage SR result.
- `iw_wb_tgt_sr`  in  2  WB-stage SR target (commit).
- `iw_wb_tgt_sr_we`  in  1  WB commit enable.
- `iw_wb_sr_result`  in  SR_W  WB commit data.
- `iw_flush`  in  1  squash EX-stage forwarding this cycle.
- `iw_stall`  in  1  pipeline stall; does not block commit or counter.
- `ow_fl`  out  FL_W  committed flags (SR2[FL_W-1:0]).
- `ow_cyc`  out  SR_W  committed SR3.

Behaviour:
- Reset (`iw_rst`=0, async):
  - SR0..SR3 cleared to 0.
  - `ow_fl`=0, `ow_cyc`=0.
  - Read outputs show 0 because no stage write is valid while the pipeline is in reset.
- Storage:
  - SR0 and SR1 are full SR_W registers.
  - SR2 stores only bits [FL_W-1:0]; upper bits read as 0 on every path, including forwarded values (mask applied at the mux output).
  - SR3 is a counter.
- Commit: on a rising edge with `iw_wb_tgt_sr_we`=1, SR[`iw_wb_tgt_sr`] <= `iw_wb_sr_result` (SR2 masked).
- Counter (`CYC_EN`=1):
  - Each edge, SR3 <= SR3+1, wrapping modulo 2^SR_W (FFFF_FFFF_FFFF -> 0).
  - A WB write to SR3 has priority: SR3 <= data that cycle, then increments from it the next edge.
  - Stall does not freeze the counter.
- Reads: combinational, zero latency, independent for ports A and B. Priority, youngest first:
  1. EX: if `iw_ex_tgt_sr_we` && !`iw_flush` && index match.
  2. MA: if `iw_ma_tgt_sr_we` && index match.
  3. WB: if `iw_wb_tgt_sr_we` && index match (same-cycle write-through).
  4. Stored register.
- Reading SR3 with no matching forward returns the current (pre-increment) counter value.
- Simultaneous writes: EX, MA and WB may all target the same index; the read returns EX. Only WB modifies storage.
- `iw_stall` has no effect inside this block; upstream stages hold their own write-enables.
- Reset asserted mid-operation clears storage immediately. A WB write coincident with reset is dropped.
- No X propagation: undriven indices never occur because all 2-bit values are valid.

Decomposition:
- SR index constants belong in shared `src/sizes.vh` or a new `src/sr.vh`: `` `SR_LR``=0, `` `SR_SSP``=1, `` `SR_FL``=2, `` `SR_CYC``=3, `` `HBIT_SR_IDX``=1.
- Flag bit positions come from `src/flags.vh`.
- One sub-module, `sr_fwd_mux`:
  - Takes one read index, the three stage write triples, the flush bit and the stored vector.
  - Returns the masked forwarded value.
  - Instantiated twice, once per read port.

Test Plan:
1. Reset, then release; read SR0..SR3 on both ports -> SR0..SR2 = 0, SR3 = cycle count since release (1 after first edge); `ow_fl`=0.
2. WB write SR2 = 0x00000000000F, next cycle read `iw_src_sr`=2 -> 0x00000000000F, `ow_fl`=4'b1111. WB write SR2 = 0xFFFFFFFFFFF1 -> read 0x000000000001.
3. Memory holds SR2=0; EX we SR2=0x1 (Z) and MA we SR2=0x4 (C) in the same cycle -> `ow_src_sr_val`=0x1. Same cycle with `iw_flush`=1 -> 0x4.
4. Same-cycle WB write SR0=0x123456789ABC while reading SR0 -> output 0x123456789ABC in that cycle; stored value matches after the edge.
5. WB write SR3=0xFFFFFFFFFFFE -> next cycle read 0xFFFFFFFFFFFE, then 0xFFFFFFFFFFFF, then 0x000000000000 (wrap). `iw_stall`=1 throughout does not stop the count.
6. Mid-stream reset: SR1=0xABC committed, assert `iw_rst`=0 between edges -> SR1 reads 0 immediately, before any clock edge.

Source files
------------

// File: rtl/sr_file_fwd_pkg.sv
// rtl/sr_file_fwd_pkg.sv - shared SR-space constants and index encoding
//   Provides default widths, the SR index enum and flag bit positions
//   used by sr_file_fwd and sr_fwd_mux.
package sr_file_fwd_pkg;

    localparam int HBIT_ADDR   = 47;
    localparam int SR_W_DEF    = HBIT_ADDR + 1;
    localparam int FL_W_DEF    = 4;
    localparam int HBIT_SR_IDX = 1;

    typedef enum logic [HBIT_SR_IDX:0] {
        SR_LR  = 2'd0,
        SR_SSP = 2'd1,
        SR_FL  = 2'd2,
        SR_CYC = 2'd3
    } sr_idx_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/sr_fwd_mux.sv
// rtl/sr_fwd_mux.sv - per-read-port SR forwarding mux (EX > MA > WB > stored)
//   i_idx             : read index
//   i_ex_* / i_ma_* / i_wb_* : stage target, write-valid, result
//   i_flush           : squashes the EX forward
//   i_stored          : committed SR0..SR3 (SR2 already zero-extended)
//   o_val             : forwarded value, FL upper bits masked
module sr_fwd_mux
    import sr_file_fwd_pkg::*;
#(
    parameter int SR_W = SR_W_DEF,
    parameter int FL_W = FL_W_DEF
) (
    input  logic [1:0]                 i_idx,
    input  logic [1:0]                 i_ex_tgt,
    input  logic                       i_ex_we,
    input  logic [SR_W-1:0]            i_ex_result,
    input  logic [1:0]                 i_ma_tgt,
    input  logic                       i_ma_we,
    input  logic [SR_W-1:0]            i_ma_result,
    input  logic [1:0]                 i_wb_tgt,
    input  logic                       i_wb_we,
    input  logic [SR_W-1:0]            i_wb_result,
    input  logic                       i_flush,
    input  logic [3:0][SR_W-1:0]       i_stored,
    output logic [SR_W-1:0]            o_val
);

    localparam logic [SR_W-1:0] FL_MASK = {{(SR_W-FL_W){1'b0}}, {FL_W{1'b1}}};

    logic [SR_W-1:0] w_sel;

    // Oldest source first so the youngest matching stage overrides.
    always_comb begin
        w_sel = i_stored[i_idx];
        if (i_wb_we && (i_wb_tgt == i_idx))
            w_sel = i_wb_result;
        if (i_ma_we && (i_ma_tgt == i_idx))
            w_sel = i_ma_result;
        if (i_ex_we && !i_flush && (i_ex_tgt == i_idx))
            w_sel = i_ex_result;
    end

    // Forwarded FL values must look exactly like the narrow stored register.
    assign o_val = (i_idx == SR_FL) ? (w_sel & FL_MASK) : w_sel;

endmodule

// File: rtl/sr_file_fwd.sv
// rtl/sr_file_fwd.sv - special-register file with EX/MA/WB forwarding
//   iw_clk/iw_rst            : clock, async active-low reset
//   iw_src_sr/iw_tgt_sr      : read indices A/B -> ow_src_sr_val/ow_tgt_sr_val
//   iw_ex_*/iw_ma_*          : in-flight SR results for forwarding
//   iw_wb_*                  : commit port (also forwarded same cycle)
//   iw_flush                 : squash EX forward; iw_stall is ignored here
//   ow_fl / ow_cyc           : committed flags and cycle counter
module sr_file_fwd
    import sr_file_fwd_pkg::*;
#(
    parameter int SR_W   = SR_W_DEF,
    parameter int FL_W   = FL_W_DEF,
    parameter int CYC_EN = 1
) (
    input  logic                iw_clk,
    input  logic                iw_rst,
    input  logic [1:0]          iw_src_sr,
    input  logic [1:0]          iw_tgt_sr,
    output logic [SR_W-1:0]     ow_src_sr_val,
    output logic [SR_W-1:0]     ow_tgt_sr_val,
    input  logic [1:0]          iw_ex_tgt_sr,
    input  logic                iw_ex_tgt_sr_we,
    input  logic [SR_W-1:0]     iw_ex_sr_result,
    input  logic [1:0]          iw_ma_tgt_sr,
    input  logic                iw_ma_tgt_sr_we,
    input  logic [SR_W-1:0]     iw_ma_sr_result,
    input  logic [1:0]          iw_wb_tgt_sr,
    input  logic                iw_wb_tgt_sr_we,
    input  logic [SR_W-1:0]     iw_wb_sr_result,
    input  logic                iw_flush,
    input  logic                iw_stall,
    output logic [FL_W-1:0]     ow_fl,
    output logic [SR_W-1:0]     ow_cyc
);

    logic [SR_W-1:0]       r_sr0;
    logic [SR_W-1:0]       r_sr1;
    logic [FL_W-1:0]       r_fl;
    logic [SR_W-1:0]       r_cyc;
    logic [3:0][SR_W-1:0]  w_stored;
    logic                  w_unused_stall;

    // Upstream stages hold their own write-enables during a stall.
    assign w_unused_stall = iw_stall;

    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            r_sr0 <= '0;
            r_sr1 <= '0;
            r_fl  <= '0;
            r_cyc <= '0;
        end else begin
            if (iw_wb_tgt_sr_we && (iw_wb_tgt_sr == SR_LR))
                r_sr0 <= iw_wb_sr_result;
            if (iw_wb_tgt_sr_we && (iw_wb_tgt_sr == SR_SSP))
                r_sr1 <= iw_wb_sr_result;
            if (iw_wb_tgt_sr_we && (iw_wb_tgt_sr == SR_FL))
                r_fl <= iw_wb_sr_result[FL_W-1:0];
            // A committed write to the counter wins over the increment.
            if (iw_wb_tgt_sr_we && (iw_wb_tgt_sr == SR_CYC))
                r_cyc <= iw_wb_sr_result;
            else if (CYC_EN != 0)
                r_cyc <= r_cyc + SR_W'(1);
        end
    end

    assign w_stored[0] = r_sr0;
    assign w_stored[1] = r_sr1;
    assign w_stored[2] = {{(SR_W-FL_W){1'b0}}, r_fl};
    assign w_stored[3] = r_cyc;

    sr_fwd_mux #(.SR_W(SR_W), .FL_W(FL_W)) u_mux_src (
        .i_idx       (iw_src_sr),
        .i_ex_tgt    (iw_ex_tgt_sr),
        .i_ex_we     (iw_ex_tgt_sr_we),
        .i_ex_result (iw_ex_sr_result),
        .i_ma_tgt    (iw_ma_tgt_sr),
        .i_ma_we     (iw_ma_tgt_sr_we),
        .i_ma_result (iw_ma_sr_result),
        .i_wb_tgt    (iw_wb_tgt_sr),
        .i_wb_we     (iw_wb_tgt_sr_we),
        .i_wb_result (iw_wb_sr_result),
        .i_flush     (iw_flush),
        .i_stored    (w_stored),
        .o_val       (ow_src_sr_val)
    );

    sr_fwd_mux #(.SR_W(SR_W), .FL_W(FL_W)) u_mux_tgt (
        .i_idx       (iw_tgt_sr),
        .i_ex_tgt    (iw_ex_tgt_sr),
        .i_ex_we     (iw_ex_tgt_sr_we),
        .i_ex_result (iw_ex_sr_result),
        .i_ma_tgt    (iw_ma_tgt_sr),
        .i_ma_we     (iw_ma_tgt_sr_we),
        .i_ma_result (iw_ma_sr_result),
        .i_wb_tgt    (iw_wb_tgt_sr),
        .i_wb_we     (iw_wb_tgt_sr_we),
        .i_wb_result (iw_wb_sr_result),
        .i_flush     (iw_flush),
        .i_stored    (w_stored),
        .o_val       (ow_tgt_sr_val)
    );

    assign ow_fl  = r_fl;
    assign ow_cyc = r_cyc;

endmodule

// File: tb/tb_sr_file_fwd.sv
// tb/tb_sr_file_fwd.sv - self-checking bench for sr_file_fwd
module tb_sr_file_fwd;

    localparam int W = 48;
    localparam logic [W-1:0] FLM = 48'hF;

    logic          iw_clk = 1'b0;
    logic          iw_rst = 1'b0;
    logic [1:0]    iw_src_sr = '0, iw_tgt_sr = '0;
    logic [W-1:0]  ow_src_sr_val, ow_tgt_sr_val;
    logic [1:0]    iw_ex_tgt_sr = '0, iw_ma_tgt_sr = '0, iw_wb_tgt_sr = '0;
    logic          iw_ex_tgt_sr_we = 1'b0, iw_ma_tgt_sr_we = 1'b0, iw_wb_tgt_sr_we = 1'b0;
    logic [W-1:0]  iw_ex_sr_result = '0, iw_ma_sr_result = '0, iw_wb_sr_result = '0;
    logic          iw_flush = 1'b0, iw_stall = 1'b0;
    logic [3:0]    ow_fl;
    logic [W-1:0]  ow_cyc;

    int n_chk = 0;
    int n_fail = 0;

    logic [W-1:0] m_sr [4];

    sr_file_fwd dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst),
        .iw_src_sr(iw_src_sr), .iw_tgt_sr(iw_tgt_sr),
        .ow_src_sr_val(ow_src_sr_val), .ow_tgt_sr_val(ow_tgt_sr_val),
        .iw_ex_tgt_sr(iw_ex_tgt_sr), .iw_ex_tgt_sr_we(iw_ex_tgt_sr_we), .iw_ex_sr_result(iw_ex_sr_result),
        .iw_ma_tgt_sr(iw_ma_tgt_sr), .iw_ma_tgt_sr_we(iw_ma_tgt_sr_we), .iw_ma_sr_result(iw_ma_sr_result),
        .iw_wb_tgt_sr(iw_wb_tgt_sr), .iw_wb_tgt_sr_we(iw_wb_tgt_sr_we), .iw_wb_sr_result(iw_wb_sr_result),
        .iw_flush(iw_flush), .iw_stall(iw_stall),
        .ow_fl(ow_fl), .ow_cyc(ow_cyc)
    );

    always #5 iw_clk = ~iw_clk;

    // Reference read: youngest valid writer wins, FL reads are 4 bits wide.
    function automatic logic [W-1:0] mdl_read(input logic [1:0] idx);
        logic [W-1:0] v;
        if (iw_ex_tgt_sr_we && !iw_flush && iw_ex_tgt_sr == idx) v = iw_ex_sr_result;
        else if (iw_ma_tgt_sr_we && iw_ma_tgt_sr == idx)        v = iw_ma_sr_result;
        else if (iw_wb_tgt_sr_we && iw_wb_tgt_sr == idx)        v = iw_wb_sr_result;
        else                                                    v = m_sr[idx];
        if (idx == 2'd2) v = v % 16;
        return v;
    endfunction

    task automatic idle();
        iw_ex_tgt_sr_we = 1'b0; iw_ma_tgt_sr_we = 1'b0; iw_wb_tgt_sr_we = 1'b0;
        iw_flush = 1'b0; iw_stall = 1'b0;
    endtask

    // One clock edge with the model following the committed architecture state.
    task automatic tick();
        logic [W-1:0] nxt [4];
        for (int i = 0; i < 4; i++) nxt[i] = m_sr[i];
        nxt[3] = m_sr[3] + 48'd1;
        if (iw_wb_tgt_sr_we) nxt[iw_wb_tgt_sr] = (iw_wb_tgt_sr == 2'd2) ? (iw_wb_sr_result % 16) : iw_wb_sr_result;
        @(posedge iw_clk);
        #1;
        for (int i = 0; i < 4; i++) m_sr[i] = nxt[i];
    endtask

    task automatic test_reset();
        idle();
        iw_rst = 1'b0;
        for (int i = 0; i < 4; i++) m_sr[i] = '0;
        repeat (3) @(posedge iw_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            iw_src_sr = 2'(i); iw_tgt_sr = 2'(3 - i); #1;
            n_chk++;
            if (ow_src_sr_val !== 48'd0 || ow_tgt_sr_val !== 48'd0) begin
                n_fail++;
                $display("FAIL reset_read idx=%0d got src=%h tgt=%h want 0", i, ow_src_sr_val, ow_tgt_sr_val);
            end
        end
        n_chk++;
        if (ow_fl !== 4'd0 || ow_cyc !== 48'd0) begin
            n_fail++; $display("FAIL reset_fl_cyc got fl=%h cyc=%h want 0/0", ow_fl, ow_cyc);
        end
        @(negedge iw_clk);
        iw_rst = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            iw_src_sr = 2'(i); iw_tgt_sr = 2'(i); #1;
            n_chk++;
            if (ow_src_sr_val !== ((i == 3) ? 48'd1 : 48'd0) || ow_tgt_sr_val !== ((i == 3) ? 48'd1 : 48'd0)) begin
                n_fail++;
                $display("FAIL release_read idx=%0d got src=%h tgt=%h", i, ow_src_sr_val, ow_tgt_sr_val);
            end
        end
        n_chk++;
        if (ow_fl !== 4'd0 || ow_cyc !== 48'd1) begin
            n_fail++; $display("FAIL release_fl_cyc got fl=%h cyc=%h want 0/1", ow_fl, ow_cyc);
        end
    endtask

    task automatic test_fl_mask();
        idle();
        iw_wb_tgt_sr_we = 1'b1; iw_wb_tgt_sr = 2'd2; iw_wb_sr_result = 48'h00000000000F;
        tick();
        idle();
        iw_src_sr = 2'd2; #1;
        n_chk++;
        if (ow_src_sr_val !== 48'hF || ow_fl !== 4'hF) begin
            n_fail++; $display("FAIL fl_write_f got val=%h fl=%h want f/f", ow_src_sr_val, ow_fl);
        end
        iw_wb_tgt_sr_we = 1'b1; iw_wb_sr_result = 48'hFFFFFFFFFFF1; #1;
        n_chk++;
        if (ow_src_sr_val !== 48'h1) begin
            n_fail++; $display("FAIL fl_wt_mask got %h want 1", ow_src_sr_val);
        end
        tick();
        idle(); #1;
        n_chk++;
        if (ow_src_sr_val !== 48'h1 || ow_fl !== 4'h1) begin
            n_fail++; $display("FAIL fl_mask_stored got val=%h fl=%h want 1/1", ow_src_sr_val, ow_fl);
        end
    endtask

    task automatic test_fwd_priority();
        idle();
        iw_wb_tgt_sr_we = 1'b1; iw_wb_tgt_sr = 2'd2; iw_wb_sr_result = '0;
        tick();
        idle();
        iw_src_sr = 2'd2; iw_tgt_sr = 2'd2;
        iw_ex_tgt_sr_we = 1'b1; iw_ex_tgt_sr = 2'd2; iw_ex_sr_result = 48'h1;
        iw_ma_tgt_sr_we = 1'b1; iw_ma_tgt_sr = 2'd2; iw_ma_sr_result = 48'h4;
        #1;
        n_chk++;
        if (ow_src_sr_val !== 48'h1 || ow_tgt_sr_val !== 48'h1) begin
            n_fail++; $display("FAIL fwd_ex_over_ma got src=%h tgt=%h want 1", ow_src_sr_val, ow_tgt_sr_val);
        end
        iw_flush = 1'b1; #1;
        n_chk++;
        if (ow_src_sr_val !== 48'h4) begin
            n_fail++; $display("FAIL fwd_flush_ma got %h want 4", ow_src_sr_val);
        end
        // Forwarded FL value keeps only the flag bits; WB below MA/EX.
        iw_flush = 1'b0; iw_ex_sr_result = 48'hABCDEF000002;
        iw_wb_tgt_sr_we = 1'b1; iw_wb_tgt_sr = 2'd2; iw_wb_sr_result = 48'h8;
        iw_tgt_sr = 2'd0; #1;
        n_chk++;
        if (ow_src_sr_val !== 48'h2 || ow_tgt_sr_val !== m_sr[0]) begin
            n_fail++; $display("FAIL fwd_mask_ex got src=%h tgt=%h want 2/%h", ow_src_sr_val, ow_tgt_sr_val, m_sr[0]);
        end
        tick();
        idle(); #1;
        n_chk++;
        if (ow_fl !== 4'h8) begin
            n_fail++; $display("FAIL fwd_only_wb_commits got fl=%h want 8", ow_fl);
        end
    endtask

    task automatic test_write_through();
        idle();
        iw_src_sr = 2'd0;
        iw_wb_tgt_sr_we = 1'b1; iw_wb_tgt_sr = 2'd0; iw_wb_sr_result = 48'h123456789ABC; #1;
        n_chk++;
        if (ow_src_sr_val !== 48'h123456789ABC) begin
            n_fail++; $display("FAIL wt_same_cycle got %h want 123456789abc", ow_src_sr_val);
        end
        tick();
        idle(); #1;
        n_chk++;
        if (ow_src_sr_val !== 48'h123456789ABC) begin
            n_fail++; $display("FAIL wt_stored got %h want 123456789abc", ow_src_sr_val);
        end
    endtask

    task automatic test_cyc_wrap();
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 48'hFFFFFFFFFFFE; exp_seq[1] = 48'hFFFFFFFFFFFF; exp_seq[2] = 48'h0;
        idle();
        iw_stall = 1'b1;
        iw_wb_tgt_sr_we = 1'b1; iw_wb_tgt_sr = 2'd3; iw_wb_sr_result = 48'hFFFFFFFFFFFE;
        tick();
        iw_wb_tgt_sr_we = 1'b0;
        iw_src_sr = 2'd3;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++;
            if (ow_src_sr_val !== exp_seq[k] || ow_cyc !== exp_seq[k]) begin
                n_fail++; $display("FAIL cyc_wrap step=%0d got val=%h cyc=%h want %h", k, ow_src_sr_val, ow_cyc, exp_seq[k]);
            end
            tick();
        end
        iw_stall = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            iw_src_sr = 2'($urandom_range(0, 3));
            iw_tgt_sr = 2'($urandom_range(0, 3));
            iw_ex_tgt_sr = 2'($urandom_range(0, 3)); iw_ex_tgt_sr_we = 1'($urandom_range(0, 1));
            iw_ma_tgt_sr = 2'($urandom_range(0, 3)); iw_ma_tgt_sr_we = 1'($urandom_range(0, 1));
            iw_wb_tgt_sr = 2'($urandom_range(0, 3)); iw_wb_tgt_sr_we = 1'($urandom_range(0, 1));
            iw_ex_sr_result = {16'($urandom), 32'($urandom)};
            iw_ma_sr_result = {16'($urandom), 32'($urandom)};
            iw_wb_sr_result = {16'($urandom), 32'($urandom)};
            iw_flush = 1'($urandom_range(0, 1));
            iw_stall = 1'($urandom_range(0, 1));
            #1;
            n_chk++;
            if (ow_src_sr_val !== mdl_read(iw_src_sr) || ow_tgt_sr_val !== mdl_read(iw_tgt_sr) ||
                ow_fl !== m_sr[2][3:0] || ow_cyc !== m_sr[3]) begin
                n_fail++;
                $display("FAIL random c=%0d src=%h/%h tgt=%h/%h fl=%h/%h cyc=%h/%h", c,
                         ow_src_sr_val, mdl_read(iw_src_sr), ow_tgt_sr_val, mdl_read(iw_tgt_sr),
                         ow_fl, m_sr[2][3:0], ow_cyc, m_sr[3]);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        iw_wb_tgt_sr_we = 1'b1; iw_wb_tgt_sr = 2'd1; iw_wb_sr_result = 48'hABC;
        tick();
        iw_wb_tgt_sr_we = 1'b0;
        iw_src_sr = 2'd1; iw_tgt_sr = 2'd1; #1;
        n_chk++;
        if (ow_src_sr_val !== 48'hABC) begin
            n_fail++; $display("FAIL arst_pre got %h want abc", ow_src_sr_val);
        end
        #1 iw_rst = 1'b0;
        #1;
        n_chk++;
        if (ow_src_sr_val !== 48'd0 || ow_cyc !== 48'd0 || ow_fl !== 4'd0) begin
            n_fail++; $display("FAIL arst_immediate got sr1=%h cyc=%h fl=%h want 0", ow_src_sr_val, ow_cyc, ow_fl);
        end
        // A commit presented while reset is held must be dropped.
        iw_wb_tgt_sr_we = 1'b1; iw_wb_tgt_sr = 2'd0; iw_wb_sr_result = 48'h5A5A;
        @(posedge iw_clk); #1;
        iw_wb_tgt_sr_we = 1'b0;
        iw_src_sr = 2'd0; #1;
        n_chk++;
        if (ow_src_sr_val !== 48'd0) begin
            n_fail++; $display("FAIL arst_drop_wb got %h want 0", ow_src_sr_val);
        end
        for (int i = 0; i < 4; i++) m_sr[i] = '0;
        @(negedge iw_clk);
        iw_rst = 1'b1;
        tick();
        iw_src_sr = 2'd3; #1;
        n_chk++;
        if (ow_src_sr_val !== 48'd1) begin
            n_fail++; $display("FAIL arst_release_cyc got %h want 1", ow_src_sr_val);
        end
    endtask

    initial begin
        test_reset();
        test_fl_mask();
        test_fwd_priority();
        test_write_through();
        test_cyc_wrap();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
